// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with a built-in test-pattern source.
// All outputs are registered and describe the pixel the raster counters just advanced to.
module vga_timing_gen #(
  parameter int CLK_DIV    = 4,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_POL   = 0,
  parameter int CNT_W      = 12,
  parameter int COLOR_W    = 4,
  parameter int CHECK_LOG2 = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [1:0]         mode,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [CNT_W-1:0]   pix_x,
  output logic [CNT_W-1:0]   pix_y,
  output logic               line_start,
  output logic               frame_start,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue
);

  localparam int   H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int   V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int   HS_START = H_ACTIVE + H_FP;
  localparam int   HS_END   = HS_START + H_SYNC;
  localparam int   VS_START = V_ACTIVE + V_FP;
  localparam int   VS_END   = VS_START + V_SYNC;
  localparam int   BW       = H_ACTIVE / 8;
  localparam int   DCNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic SYNC_ON  = (SYNC_POL != 0);

  generate
    if (CLK_DIV < 1 || H_ACTIVE < 8 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || COLOR_W < 1 ||
        CNT_W < 1 || CNT_W > 30 || CHECK_LOG2 < 0 || CHECK_LOG2 >= CNT_W ||
        H_TOTAL >= (2 ** CNT_W) || V_TOTAL >= (2 ** CNT_W)) begin : g_param_check
      $error("vga_timing_gen: illegal parameter set");
    end
  endgenerate

  logic [DCNT_W-1:0]    dcnt;
  logic [CNT_W-1:0]     hcnt, vcnt, nx, ny;
  logic [CNT_W-1:0]     bar_cnt, bar_cnt_nx;
  logic [2:0]           bar_idx, bar_nx;
  logic [1:0]           mode_sh, mode_nx;
  logic [3*COLOR_W-1:0] rgb;
  logic                 pix_ce, h_last, v_last, first_px;
  logic                 de_nx, hs_nx, vs_nx, chk_nx;

  function automatic logic [3*COLOR_W-1:0] pattern(input logic [1:0] m, input logic [2:0] bar,
                                                   input logic chk, input logic act);
    logic [2:0] c;
    c = 3'd0;
    case (m)
      2'd0:    c = 3'd0;
      2'd1:    c = 3'd7;
      2'd2:    c = 3'd7 - bar;
      default: c = {3{chk}};
    endcase
    if (!act) c = 3'd0;
    return {{COLOR_W{c[2]}}, {COLOR_W{c[1]}}, {COLOR_W{c[0]}}};
  endfunction

  always_comb begin
    pix_ce   = (CLK_DIV == 1) ? 1'b1 : (dcnt == DCNT_W'(CLK_DIV - 1));
    h_last   = (hcnt == CNT_W'(H_TOTAL - 1));
    v_last   = (vcnt == CNT_W'(V_TOTAL - 1));
    nx       = h_last ? '0 : hcnt + 1'b1;
    ny       = vcnt;
    if (h_last) ny = v_last ? '0 : vcnt + 1'b1;
    first_px = (nx == '0) && (ny == '0);
    mode_nx  = first_px ? mode : mode_sh;
    // Bar index follows x through a per-bar pixel counter; bar 7 absorbs the remainder.
    bar_nx     = bar_idx;
    bar_cnt_nx = bar_cnt + 1'b1;
    if (nx == '0) begin
      bar_nx     = 3'd0;
      bar_cnt_nx = '0;
    end else if (bar_idx != 3'd7 && bar_cnt == CNT_W'(BW - 1)) begin
      bar_nx     = bar_idx + 1'b1;
      bar_cnt_nx = '0;
    end
    de_nx  = (nx < CNT_W'(H_ACTIVE)) && (ny < CNT_W'(V_ACTIVE));
    hs_nx  = (nx >= CNT_W'(HS_START)) && (nx < CNT_W'(HS_END));
    vs_nx  = (ny >= CNT_W'(VS_START)) && (ny < CNT_W'(VS_END));
    chk_nx = nx[CHECK_LOG2] ^ ny[CHECK_LOG2];
  end

  // Reset and en=0 park the counters on the last pixel so the next pix_ce presents (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt        <= '0;
      hcnt        <= CNT_W'(H_TOTAL - 1);
      vcnt        <= CNT_W'(V_TOTAL - 1);
      bar_idx     <= 3'd0;
      bar_cnt     <= '0;
      mode_sh     <= 2'd0;
      pix_x       <= '0;
      pix_y       <= '0;
      de          <= 1'b0;
      hsync       <= ~SYNC_ON;
      vsync       <= ~SYNC_ON;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      rgb         <= '0;
    end else if (!en) begin
      dcnt        <= '0;
      hcnt        <= CNT_W'(H_TOTAL - 1);
      vcnt        <= CNT_W'(V_TOTAL - 1);
      bar_idx     <= 3'd0;
      bar_cnt     <= '0;
      mode_sh     <= 2'd0;
      pix_x       <= '0;
      pix_y       <= '0;
      de          <= 1'b0;
      hsync       <= ~SYNC_ON;
      vsync       <= ~SYNC_ON;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      rgb         <= '0;
    end else begin
      dcnt        <= pix_ce ? '0 : dcnt + 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_ce) begin
        hcnt        <= nx;
        vcnt        <= ny;
        bar_idx     <= bar_nx;
        bar_cnt     <= bar_cnt_nx;
        mode_sh     <= mode_nx;
        pix_x       <= nx;
        pix_y       <= ny;
        de          <= de_nx;
        hsync       <= hs_nx ? SYNC_ON : ~SYNC_ON;
        vsync       <= vs_nx ? SYNC_ON : ~SYNC_ON;
        line_start  <= (nx == '0);
        frame_start <= first_px;
        rgb         <= pattern(mode_nx, bar_nx, chk_nx, de_nx);
      end
    end
  end

  assign {red, green, blue} = rgb;

endmodule
